bus_slave_port: RTL
===================

# bus_slave_port

Serial bus responder that ends a master transaction on the system bus and turns it into word accesses on a local 4K×8 block RAM. It receives address, burst count and, for writes, data bytes bit-serially from the bus. For reads, it serialises RAM data back to the master. It sits between the bus interconnect (slave-select decode) and one RAM slave, and answers the read/write/address/data/burst commands that masters issue.

## Interface
- ADDR_LEN, 12, RAM word-address width
- DATA_LEN, 8, data word width
- BURST_LEN, 12, burst-count field width
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- slave_select  in  1  interconnect grant to this slave; held high for the whole transaction
- mode  in  1  1 = write, 0 = read; sampled on the start cycle only
- m_valid  in  1  master serial bit valid
- m_data  in  1  master serial bit, LSB first
- s_valid  out  1  read-data serial bit valid
- s_data  out  1  read-data serial bit, LSB first
- s_ready  out  1  high only in IDLE (ready for a new transaction)
- s_done  out  1  one-cycle pulse at transaction completion
- mem_addr  out  ADDR_LEN  RAM address
- mem_wdata  out  DATA_LEN  RAM write data
- mem_we  out  1  RAM write enable, one cycle per word
- mem_rdata  in  DATA_LEN  RAM read data, valid one cycle after mem_addr (registered RAM)

## Operation
- Reset (synchronous, clk edge with reset=1) puts the block in IDLE.
  - Reset values: s_ready=1; s_valid, s_data, s_done, mem_we = 0; mem_addr, mem_wdata = 0.
  - All counters and shift registers clear.
- Reset mid-transaction aborts immediately. No further mem_we is issued.
- States: IDLE, RX_ADDR, RX_BURST, RX_DATA, MEM_WRITE, READ_REQ, READ_WAIT, TX_DATA, DONE.
- IDLE → RX_ADDR on slave_select=1 and m_valid=1. That bit is address bit 0, and mode latches in the same cycle.
- RX_ADDR: shifts ADDR_LEN bits, counting only cycles with m_valid=1. Gaps in m_valid are allowed.
- RX_BURST: shifts BURST_LEN bits. A burst count of 0 is treated as 1. The maximum is 2^BURST_LEN−1 (0xFFF).
- After the burst field:
  - Write → RX_DATA.
  - Read → READ_REQ.
- RX_DATA: shifts DATA_LEN bits, then goes to MEM_WRITE.
- MEM_WRITE (1 cycle):
  - mem_we=1, with mem_addr = current address and mem_wdata = the assembled byte.
  - Address increments and the remaining count decrements.
  - Next state is RX_DATA, or DONE when the count reaches 0.
- READ_REQ (1 cycle): drives mem_addr.
- READ_WAIT (1 cycle): latches mem_rdata into the TX shift register.
- TX_DATA: DATA_LEN cycles with s_valid=1, LSB first. Afterwards, address increments, count decrements, and the next state is READ_REQ or DONE.
- DONE (1 cycle): s_done=1, then IDLE.
- Address arithmetic is modulo 2^ADDR_LEN: 0xFFF+1 wraps to 0x000.
- slave_select=0 in any non-IDLE state aborts to IDLE on the next edge:
  - no s_done;
  - an in-progress MEM_WRITE cycle completes, but no later writes occur.
- m_valid outside RX states is ignored. In IDLE, m_valid with slave_select=0 is ignored.
- slave_select and m_valid rising together with a DONE→IDLE transition are not accepted until s_ready=1.

## Timing
- Write byte: last data bit accepted at cycle T → mem_we at T+1 → next data bit can be accepted at T+2.
- Read: last burst bit at T:
  - mem_addr valid at T+1;
  - mem_rdata captured at T+2;
  - first s_valid bit at T+3.
- Read byte period is DATA_LEN+2 cycles (10 cycles at defaults).
- s_done occurs one cycle after the final mem_we (write) or the final s_valid bit (read). s_ready rises the cycle after s_done.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package bus_pkg holds:
  - ADDR_LEN, DATA_LEN, BURST_LEN defaults;
  - the MODE_READ/MODE_WRITE constants;
  - the slave state enum.
  The same package is shared with the masters and the interconnect.
- One sub-module: serial_shift_rx, a width-parameterised SIPO with a bit counter and a full flag. It is instantiated once and reused for the address, burst and data fields by reloading the width.
- The TX shift register and the FSM stay inline.

## Test plan
- Single write: address 0x005, burst 1, data 0xA5 → one mem_we with mem_addr=0x005, mem_wdata=0xA5; s_done 1 cycle later.
- Burst read: address 0x010, burst 3, RAM holding 0x11, 0x22, 0x33 → s_data streams 0x11, 0x22, 0x33 LSB first; 10-cycle byte period; first bit at T+3.
- Wrap-around: write burst 2 at address 0xFFF with data 0x01, 0x02 → writes go to 0xFFF then 0x000.
- Burst 0 and gaps: burst field 0 with random m_valid gaps → exactly one word transferred, bits counted only on m_valid.
- Abort: slave_select drops after 4 data bits of the second write byte → only the first mem_we occurs; no s_done; s_ready=1 one cycle later.
- Reset mid-read during TX_DATA → next edge: s_valid=0, s_ready=1; a new transaction is accepted normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions: field widths, transfer mode encoding and slave FSM states.
// Used by the masters, the interconnect and the slave port.
package bus_pkg;

  localparam int unsigned ADDR_LEN  = 12;
  localparam int unsigned DATA_LEN  = 8;
  localparam int unsigned BURST_LEN = 12;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  typedef enum logic [3:0] {
    StIdle,
    StRxAddr,
    StRxBurst,
    StRxData,
    StMemWrite,
    StReadReq,
    StReadWait,
    StTxData,
    StDone
  } slave_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serial_shift_rx.sv
// LSB-first serial-in/parallel-out register with a bit counter; the field width is
// supplied per field so one instance can assemble address, burst and data in turn.
module serial_shift_rx #(
  parameter int unsigned MaxWidth = 12,
  parameter int unsigned CntW     = $clog2(MaxWidth + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [CntW-1:0]     width,
  input  logic                bit_valid,
  input  logic                bit_in,
  output logic [MaxWidth-1:0] word,
  output logic                full
);

  logic [MaxWidth-1:0] data_q;
  logic [CntW-1:0]     cnt_q;

  // word already includes the bit arriving this cycle, so the field is usable as full rises
  always_comb begin
    word = data_q | (MaxWidth'(bit_valid & bit_in) << cnt_q);
    full = bit_valid && ((cnt_q + CntW'(1)) == width);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (bit_valid) begin
      data_q <= word;
      cnt_q  <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/bus_slave_port.sv
// Serial bus slave: receives address/burst/data bit-serially and performs word
// accesses on a registered block RAM, serialising read data back to the master.
module bus_slave_port
  import bus_pkg::*;
#(
  parameter int unsigned AddrLen  = ADDR_LEN,
  parameter int unsigned DataLen  = DATA_LEN,
  parameter int unsigned BurstLen = BURST_LEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               slave_select,
  input  logic               mode,
  input  logic               m_valid,
  input  logic               m_data,
  output logic               s_valid,
  output logic               s_data,
  output logic               s_ready,
  output logic               s_done,
  output logic [AddrLen-1:0] mem_addr,
  output logic [DataLen-1:0] mem_wdata,
  output logic               mem_we,
  input  logic [DataLen-1:0] mem_rdata
);

  localparam int unsigned FieldW = max3(AddrLen, BurstLen, DataLen);
  localparam int unsigned CntW   = $clog2(FieldW + 1);
  localparam int unsigned TxCntW = $clog2(DataLen + 1);

  slave_state_e        state_q, state_d;
  logic [AddrLen-1:0]  addr_q, addr_d;
  logic [BurstLen-1:0] cnt_q, cnt_d;
  logic                mode_q, mode_d;
  logic [DataLen-1:0]  tx_q, tx_d;
  logic [TxCntW-1:0]   tx_cnt_q, tx_cnt_d;
  logic                s_data_d;
  logic [AddrLen-1:0]  mem_addr_d;
  logic [DataLen-1:0]  mem_wdata_d;
  logic                mem_we_d;

  logic              abort, start, rx_state;
  logic              shift_valid, shift_clear, shift_full;
  logic [CntW-1:0]   field_width;
  logic [FieldW-1:0] shift_word;

  assign abort    = (state_q != StIdle) && !slave_select;
  assign start    = (state_q == StIdle) && slave_select && m_valid;
  assign rx_state = (state_q == StRxAddr) || (state_q == StRxBurst) || (state_q == StRxData);

  // The start bit is address bit 0, so the shifter already runs in the IDLE start cycle
  assign shift_valid = m_valid && !abort && (rx_state || start);
  assign shift_clear = abort || shift_full || !(rx_state || start);

  always_comb begin
    case (state_q)
      StRxBurst: field_width = CntW'(BurstLen);
      StRxData:  field_width = CntW'(DataLen);
      default:   field_width = CntW'(AddrLen);
    endcase
  end

  serial_shift_rx #(
    .MaxWidth (FieldW),
    .CntW     (CntW)
  ) u_shift_rx (
    .clk       (clk),
    .reset     (reset),
    .clear     (shift_clear),
    .width     (field_width),
    .bit_valid (shift_valid),
    .bit_in    (m_data),
    .word      (shift_word),
    .full      (shift_full)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    tx_d        = tx_q;
    tx_cnt_d    = tx_cnt_q;
    s_data_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_we_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = mode;
          state_d = StRxAddr;
        end
      end
      StRxAddr: begin
        if (shift_full) begin
          addr_d  = shift_word[AddrLen-1:0];
          state_d = StRxBurst;
        end
      end
      StRxBurst: begin
        if (shift_full) begin
          cnt_d = (shift_word[BurstLen-1:0] == '0) ? BurstLen'(1) : shift_word[BurstLen-1:0];
          if (mode_q == MODE_WRITE) begin
            state_d = StRxData;
          end else begin
            mem_addr_d = addr_q;
            state_d    = StReadReq;
          end
        end
      end
      StRxData: begin
        if (shift_full) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = shift_word[DataLen-1:0];
          state_d     = StMemWrite;
        end
      end
      StMemWrite: begin
        addr_d  = addr_q + AddrLen'(1);
        cnt_d   = cnt_q - BurstLen'(1);
        state_d = (cnt_q == BurstLen'(1)) ? StDone : StRxData;
      end
      StReadReq: state_d = StReadWait;
      StReadWait: begin
        s_data_d = mem_rdata[0];
        tx_d     = mem_rdata >> 1;
        tx_cnt_d = '0;
        state_d  = StTxData;
      end
      StTxData: begin
        if (tx_cnt_q == TxCntW'(DataLen - 1)) begin
          addr_d = addr_q + AddrLen'(1);
          cnt_d  = cnt_q - BurstLen'(1);
          if (cnt_q == BurstLen'(1)) begin
            state_d = StDone;
          end else begin
            mem_addr_d = addr_q + AddrLen'(1);
            state_d    = StReadReq;
          end
        end else begin
          s_data_d = tx_q[0];
          tx_d     = tx_q >> 1;
          tx_cnt_d = tx_cnt_q + TxCntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d  = StIdle;
      mem_we_d = 1'b0;
      s_data_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      cnt_q     <= '0;
      mode_q    <= MODE_READ;
      tx_q      <= '0;
      tx_cnt_q  <= '0;
      s_valid   <= 1'b0;
      s_data    <= 1'b0;
      s_ready   <= 1'b1;
      s_done    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      tx_q      <= tx_d;
      tx_cnt_q  <= tx_cnt_d;
      s_valid   <= (state_d == StTxData);
      s_data    <= s_data_d;
      s_ready   <= (state_d == StIdle);
      s_done    <= (state_d == StDone);
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_we    <= mem_we_d;
    end
  end

endmodule
